// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: synchroniser, start/data/parity/stop framing FSM and a
// valid/ready holding register that reports parity, framing and overrun errors.
module uart_rx_framed #(
  parameter int BAUD_MULT   = 139,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_uart_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_data,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_byte_out,
  output logic                 o_data_valid,
  output logic                 o_rx_active,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  localparam int CNT_W = $clog2(BAUD_MULT);
  localparam logic [CNT_W-1:0] CHK       = CNT_W'(BAUD_MULT >> 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(BAUD_MULT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rxs;
  logic                   armed_q;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 tick, done, done_ferr, accept;

  assign rxs = sync_q[SYNC_STAGES-1];

  // fill_q tracks when rxs reflects the real line rather than the reset value,
  // so a line held low through reset never arms the receiver.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx_data};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & rxs);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done      = 1'b0;
    done_ferr = ferr_q | ~rxs;
    tick      = (cnt_q == CHK);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxs) state_d = START;
      end
      START: if (tick) begin
        if (rxs) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      DATA: if (tick) begin
        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: if (tick) begin
        perr_d  = ((^shift_q) ^ rxs) != ODD;
        state_d = STOP;
      end
      STOP: if (tick) begin
        ferr_d = done_ferr;
        bit_d  = bit_q + 1'b1;
        // Leave on the final stop sample so the next start edge can resync early.
        if (bit_q == LAST_STOP) begin
          done    = 1'b1;
          state_d = (done_ferr && !rxs) ? BRK : IDLE;
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      o_rx_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      o_rx_active <= (state_d == START) || (state_d == DATA) ||
                     (state_d == PAR) || (state_d == STOP);
    end
  end

  always_ff @(posedge i_uart_clk) begin
    shift_q <= shift_d;
  end

  assign accept = o_data_valid & i_rx_ready;

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_byte_out   <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (accept) o_overrun <= 1'b0;
      if (done) begin
        if (!o_data_valid || accept) begin
          o_byte_out   <= shift_q;
          o_data_valid <= 1'b1;
          o_parity_err <= perr_q;
          o_frame_err  <= done_ferr;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (accept) begin
        o_byte_out   <= '0;
        o_data_valid <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 instance and a 7-bit even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_framed;
  localparam int BM   = 16;
  localparam int CHK  = BM / 2;
  localparam int SYNC = 2;
  localparam int LAT0 = SYNC + 1 + CHK + (8 + 0 + 1) * BM + 1;
  localparam int LAT1 = SYNC + 1 + CHK + (7 + 1 + 1) * BM + 1;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0] byte0;
  logic [6:0] byte1;
  logic       v0, act0, pe0, fe0, ov0;
  logic       v1, act1, pe1, fe1, ov1;

  int checks = 0, errors = 0, cyc = 0;
  int cap0_n = 0, cap1_n = 0, cap0_cyc = 0, cap1_cyc = 0, vcyc0 = 0;
  logic [7:0] cap0_byte = '0;
  logic [6:0] cap1_byte = '0;
  logic       cap0_pe = 1'b0, cap0_fe = 1'b0, cap1_pe = 1'b0, cap1_fe = 1'b0;

  uart_rx_framed #(.BAUD_MULT(BM), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut0 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx0), .i_rx_ready(rdy0),
    .o_byte_out(byte0), .o_data_valid(v0), .o_rx_active(act0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0));

  uart_rx_framed #(.BAUD_MULT(BM), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut1 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx1), .i_rx_ready(rdy1),
    .o_byte_out(byte1), .o_data_valid(v1), .o_rx_active(act1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0) vcyc0 <= vcyc0 + 1;
    if (v0 && rdy0) begin
      cap0_n <= cap0_n + 1; cap0_byte <= byte0; cap0_pe <= pe0; cap0_fe <= fe0; cap0_cyc <= cyc;
    end
    if (v1 && rdy1) begin
      cap1_n <= cap1_n + 1; cap1_byte <= byte1; cap1_pe <= pe1; cap1_fe <= fe1; cap1_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0 = bits[i]; else rx1 = bits[i];
      repeat (BM) step();
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] f7e(input logic [6:0] d, input logic p);
    return {6'b0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic test_reset();
    checks++;
    if ({v0, act0, pe0, fe0, ov0, byte0} !== 13'h0) begin
      errors++; $display("FAIL reset_dut0: got %h expected 0", {v0, act0, pe0, fe0, ov0, byte0});
    end
    checks++;
    if ({v1, act1, pe1, fe1, ov1, byte1} !== 12'h0) begin
      errors++; $display("FAIL reset_dut1: got %h expected 0", {v1, act1, pe1, fe1, ov1, byte1});
    end
  endtask

  task automatic test_8n1();
    int n0, vc, t0;
    rdy0 = 1'b1;
    repeat (20) step();
    n0 = cap0_n; vc = vcyc0; t0 = cyc;
    send_bits(0, f8n1(8'hA5), 10);
    repeat (4) step();
    checks++;
    if (cap0_n !== n0 + 1) begin errors++; $display("FAIL 8n1_count: got %0d expected %0d", cap0_n - n0, 1); end
    checks++;
    if (cap0_byte !== 8'hA5) begin errors++; $display("FAIL 8n1_byte: got %h expected a5", cap0_byte); end
    checks++;
    if ({cap0_pe, cap0_fe} !== 2'b00) begin errors++; $display("FAIL 8n1_errs: got %b expected 00", {cap0_pe, cap0_fe}); end
    checks++;
    if (cap0_cyc - t0 !== LAT0) begin errors++; $display("FAIL 8n1_latency: got %0d expected %0d", cap0_cyc - t0, LAT0); end
    checks++;
    if (vcyc0 - vc !== 1) begin errors++; $display("FAIL 8n1_valid_width: got %0d expected 1", vcyc0 - vc); end
    checks++;
    if (v0 !== 1'b0) begin errors++; $display("FAIL 8n1_valid_after: got %b expected 0", v0); end
  endtask

  task automatic test_parity();
    int n1, t0;
    logic pb;
    rdy1 = 1'b1;
    repeat (5) step();
    for (int p = 0; p < 2; p++) begin
      pb = p[0];
      n1 = cap1_n; t0 = cyc;
      send_bits(1, f7e(7'h41, pb), 10);
      repeat (4) step();
      checks++;
      if (cap1_n !== n1 + 1) begin errors++; $display("FAIL par%0d_count: got %0d expected 1", p, cap1_n - n1); end
      checks++;
      if (cap1_byte !== 7'h41) begin errors++; $display("FAIL par%0d_byte: got %h expected 41", p, cap1_byte); end
      checks++;
      if ({cap1_pe, cap1_fe} !== {pb, 1'b0}) begin
        errors++; $display("FAIL par%0d_errs: got %b expected %b", p, {cap1_pe, cap1_fe}, {pb, 1'b0});
      end
      checks++;
      if (cap1_cyc - t0 !== LAT1) begin errors++; $display("FAIL par%0d_latency: got %0d expected %0d", p, cap1_cyc - t0, LAT1); end
      repeat (10) step();
    end
  endtask

  task automatic test_frame_err();
    int n0;
    logic seen;
    rdy0 = 1'b1;
    n0 = cap0_n;
    send_bits(0, 16'h0000, 10);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (act0) seen = 1'b1;
    end
    checks++;
    if (cap0_n !== n0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", cap0_n - n0); end
    checks++;
    if ({cap0_byte, cap0_pe, cap0_fe} !== 10'b0000000001) begin
      errors++; $display("FAIL ferr_flags: got %b expected 0000000001", {cap0_byte, cap0_pe, cap0_fe});
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL ferr_break_active: got %b expected 0", seen); end
    rx0 = 1'b1;
    repeat (20) step();
    send_bits(0, f8n1(8'h5A), 10);
    repeat (4) step();
    checks++;
    if (cap0_n !== n0 + 2) begin errors++; $display("FAIL ferr_resume_count: got %0d expected 2", cap0_n - n0); end
    checks++;
    if ({cap0_byte, cap0_fe} !== {8'h5A, 1'b0}) begin
      errors++; $display("FAIL ferr_resume_byte: got %h/%b expected 5a/0", cap0_byte, cap0_fe);
    end
  endtask

  task automatic test_overrun();
    int n0;
    rdy0 = 1'b0;
    step();
    send_bits(0, f8n1(8'h11), 10);
    send_bits(0, f8n1(8'h22), 10);
    repeat (4) step();
    checks++;
    if ({v0, byte0, ov0} !== {1'b1, 8'h11, 1'b1}) begin
      errors++; $display("FAIL ovr_held: got v=%b byte=%h ovr=%b expected v=1 byte=11 ovr=1", v0, byte0, ov0);
    end
    n0 = cap0_n;
    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    checks++;
    if ({v0, ov0} !== 2'b00) begin errors++; $display("FAIL ovr_after_ready: got v=%b ovr=%b expected 0 0", v0, ov0); end
    checks++;
    if (byte0 !== 8'h00) begin errors++; $display("FAIL ovr_byte_cleared: got %h expected 00", byte0); end
    checks++;
    if (cap0_n !== n0 + 1 || cap0_byte !== 8'h11) begin
      errors++; $display("FAIL ovr_transfer: got n=%0d byte=%h expected n=1 byte=11", cap0_n - n0, cap0_byte);
    end
    repeat (200) step();
    checks++;
    if (v0 !== 1'b0) begin errors++; $display("FAIL ovr_no_second: got %b expected 0", v0); end
  endtask

  task automatic test_glitch();
    int n0, vc, k_rise, k_fall;
    rdy0 = 1'b1;
    repeat (5) step();
    n0 = cap0_n; vc = vcyc0; k_rise = -1; k_fall = -1;
    rx0 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 3) rx0 = 1'b1;
      if (act0 && k_rise < 0) k_rise = k;
      if (!act0 && k_rise >= 0 && k_fall < 0) k_fall = k;
    end
    checks++;
    if (k_rise < 0) begin errors++; $display("FAIL glitch_active_rise: got none expected rise"); end
    checks++;
    if (k_fall < 0 || k_fall - k_rise > CHK + 2) begin
      errors++; $display("FAIL glitch_active_drop: got %0d cycles expected <= %0d", k_fall - k_rise, CHK + 2);
    end
    repeat (200) step();
    checks++;
    if (cap0_n !== n0 || vcyc0 !== vc) begin
      errors++; $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", vcyc0 - vc);
    end
  endtask

  task automatic test_reset_mid();
    int n0, t0;
    logic seen;
    rdy0 = 1'b1;
    n0 = cap0_n;
    rx0 = 1'b0; repeat (BM) step();
    rx0 = 1'b1; repeat (3 * BM) step();
    rx0 = 1'b0; repeat (BM / 2) step();
    rst_n = 1'b0; repeat (3) step(); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (v0 || act0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || cap0_n !== n0) begin
      errors++; $display("FAIL rstmid_quiet: got seen=%b n=%0d expected seen=0 n=0", seen, cap0_n - n0);
    end
    rx0 = 1'b1;
    repeat (20) step();
    t0 = cyc;
    send_bits(0, f8n1(8'h3C), 10);
    repeat (4) step();
    checks++;
    if (cap0_n !== n0 + 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", cap0_n - n0); end
    checks++;
    if ({cap0_byte, cap0_pe, cap0_fe} !== {8'h3C, 2'b00}) begin
      errors++; $display("FAIL rstmid_byte: got %h/%b expected 3c/00", cap0_byte, {cap0_pe, cap0_fe});
    end
    checks++;
    if (cap0_cyc - t0 !== LAT0) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", cap0_cyc - t0, LAT0); end
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    repeat (10) step();
    test_8n1();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1);
  end

endmodule
